hack_rom_loader: RTL and testbench
==================================

Name: hack_rom_loader

Overview:
UART boot loader that sits upstream of hack_cpu and fills the instruction ROM.
- Receives a framed program image over 8N1 UART.
- Writes each 16-bit word into the instruction ROM write port.
- Holds the CPU in reset until the image has loaded and its checksum matches.
- A new sync byte while the CPU is running re-asserts CPU reset and starts a reload.

Parameters:
- WIDTH, 16, instruction word width; data is always 2 bytes.
- ADDR_W, 15, ROM address width.
- CLK_FREQ, 50000000, clk frequency in Hz.
- BAUD, 115200, UART baud rate.
- TIMEOUT_CYC, 1000000, maximum clk cycles allowed between bytes during a load.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- uart_rx  in  1  asynchronous serial input, idle high
- rom_we  out  1  ROM write strobe, one-cycle pulse
- rom_addr  out  ADDR_W  ROM write address
- rom_wdata  out  WIDTH  ROM write data
- cpu_reset  out  1  reset to hack_cpu, active-high
- busy  out  1  a load is in progress
- done  out  1  last load succeeded; CPU is running
- error  out  1  sticky; last load failed

Behaviour:
Clock and reset:
- Clock clk. Reset reset is synchronous and active-high.
- Reset values: state=SYNC, rom_we=0, rom_addr=0, rom_wdata=0, cpu_reset=1, busy=0, done=0, error=0, checksum=0, word count=0.

Frame format:
- Bytes in order: 0xA5, LEN_HI, LEN_LO, then LEN words (each sent high byte first), then CHK.
- CHK is the XOR of LEN_HI, LEN_LO and every data byte. 0xA5 is excluded from CHK.

UART receiver (sub-module):
- 2-flop synchronizer on uart_rx.
- CLKS_PER_BIT = CLK_FREQ/BAUD, rounded to nearest.
- Start bit is validated at its mid-point; data is sampled mid-bit, LSB first.
- If the stop bit is 1: produces a one-cycle rx_valid with rx_data.
- If the stop bit is 0: produces rx_ferr instead, and no rx_valid.

FSM (advances only on rx_valid unless noted):
- SYNC: 0xA5 moves to LEN_HI, sets busy=1, clears error, clears checksum, sets rom_addr=0. Any other byte is ignored.
- LEN_HI, then LEN_LO: capture LEN and fold both bytes into the checksum.
  - If LEN==0 or LEN>2^ADDR_W: go to FAIL.
  - Otherwise go to DATA_HI.
- DATA_HI: latch the high byte and go to DATA_LO.
- DATA_LO, on the cycle after rx_valid:
  - rom_we=1 for exactly one cycle, rom_wdata={hi,lo}, rom_addr = current index.
  - rom_addr increments the cycle after the pulse.
  - After the LEN-th word go to CHECK; otherwise return to DATA_HI.
- CHECK: on rx_valid, compare the byte with the running checksum.
  - Match: next cycle go to RUN with cpu_reset=0, done=1, busy=0.
  - Mismatch: go to FAIL.
- RUN: CPU executes. Receiving 0xA5 sets cpu_reset=1 and done=0 in the next cycle, then enters LEN_HI exactly as from SYNC. All other bytes are ignored.
- FAIL (one cycle): error=1, busy=0, done=0, cpu_reset stays 1, then go to SYNC.

Error conditions:
- Timeout: a counter is cleared on every rx_valid. It runs only in LEN_HI through CHECK. Reaching TIMEOUT_CYC goes to FAIL.
- Frame error: rx_ferr in LEN_HI through CHECK goes to FAIL. In SYNC or RUN it is ignored.
- A failed load leaves partially written ROM contents in place. The CPU is not released.

Other rules:
- Asserting reset mid-load aborts immediately to reset values. Words already written are not rolled back.
- Words are written at most once per frame. rom_addr never exceeds LEN-1 during a load.

Decomposition:
- Package hack_loader_pkg holds:
  - the loader_state_t enum {SYNC, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, RUN, FAIL};
  - the SYNC_BYTE=8'hA5 constant;
  - a function computing CLKS_PER_BIT.
- One sub-module, hack_uart_rx, with ports clk, reset, rx, rx_valid, rx_data[7:0], rx_ferr. It is reused later by the keyboard/serial path.

Test Plan:
- Reset -> cpu_reset=1, rom_we=0, done=0, error=0, busy=0; stays so with the line idle for 10^4 cycles.
- Send A5 00 02 00 05 EC 10 FB -> two rom_we pulses: addr0=0x0005, addr1=0xEC10. After the CHK byte, cpu_reset=0, done=1, error=0.
- Same frame with CHK=0xFA -> both words are written, then error=1, cpu_reset=1, done=0, state SYNC. A following correct frame succeeds and clears error.
- Send A5 00 03 00 05, then idle for TIMEOUT_CYC+10 cycles (bench sets TIMEOUT_CYC=5000) -> error=1, cpu_reset held. Bytes 00 11 22 sent afterwards cause no rom_we.
- While in RUN, send 0x3C then A5 00 01 12 34 27 -> 0x3C is ignored. A5 re-asserts cpu_reset, addr0=0x1234 is written, and the CPU is released again.
- Send a byte with stop bit=0 during DATA_HI -> FAIL, error=1. Send LEN=0 (A5 00 00) -> error=1 with no rom_we.

Source files
------------

// File: rtl/hack_loader_pkg.sv
// ============================================================================
//  Module      : hack_loader_pkg
//  Description : Shared types, constants and helpers for the Hack ROM boot
//                loader and its UART receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hack_loader_pkg;

    // Loader FSM states, in frame order followed by the terminal states.
    typedef enum logic [2:0] {
        SYNC    = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        CHECK   = 3'd5,
        RUN     = 3'd6,
        FAIL    = 3'd7
    } loader_state_t;

    // Frame start marker; not folded into the checksum.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Clock cycles per UART bit, rounded to the nearest integer.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + (baud / 2)) / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hack_uart_rx.sv
// ============================================================================
//  Module      : hack_uart_rx
//  Description : 8N1 UART receiver. Two-flop synchronizer, mid-bit sampling,
//                LSB first. Emits a one-cycle rx_valid for a good byte or a
//                one-cycle rx_ferr when the stop bit reads low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hack_uart_rx #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_ferr
);
    import hack_loader_pkg::*;

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int HALF_CNT     = (CLKS_PER_BIT / 2 > 0) ? (CLKS_PER_BIT / 2) - 1 : 0;
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT);

    // RX_BREAK waits for the line to return high after a framing error so a
    // held-low line is not mistaken for a fresh start bit.
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_t;

    rx_state_t        state;
    logic             rx_meta;
    logic             rx_sync;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    // Bring the asynchronous line into the clk domain; idle level is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Bit-timing state machine with registered strobes and data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= 3'd0;
            shreg    <= 8'd0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_data  <= 8'd0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!rx_sync) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        // A glitch that is gone by mid-bit is not a start bit.
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            rx_valid <= 1'b1;
                            rx_data  <= shreg;
                            state    <= RX_IDLE;
                        end else begin
                            rx_ferr <= 1'b1;
                            state   <= RX_BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_BREAK: begin
                    cnt <= '0;
                    if (rx_sync) begin
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/hack_rom_loader.sv
// ============================================================================
//  Module      : hack_rom_loader
//  Description : UART boot loader for hack_cpu. Receives a framed image
//                (A5, LEN_HI, LEN_LO, words hi/lo, CHK), writes the words into
//                the instruction ROM and releases the CPU only when the XOR
//                checksum matches. A sync byte while running triggers a reload.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hack_rom_loader #(
    parameter int WIDTH       = 16,
    parameter int ADDR_W      = 15,
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD        = 115200,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [WIDTH-1:0]  rom_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);
    import hack_loader_pkg::*;

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    // Largest legal word count: one full ROM.
    localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

    loader_state_t   state;
    logic [7:0]      checksum;
    logic [7:0]      len_hi_byte;
    logic [7:0]      hi_byte;
    logic [15:0]     len;
    logic [15:0]     word_cnt;
    logic [TO_W-1:0] to_cnt;

    logic            rx_valid;
    logic            rx_ferr;
    logic [7:0]      rx_data;

    logic            in_load;
    logic            timed_out;
    logic [15:0]     len_new;
    logic            len_bad;

    hack_uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_uart_rx (
        .clk      (clk),
        .reset    (reset),
        .rx       (uart_rx),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ferr  (rx_ferr)
    );

    // States in which a frame is being received and errors abort the load.
    assign in_load   = (state == LEN_HI) || (state == LEN_LO) || (state == DATA_HI) ||
                       (state == DATA_LO) || (state == CHECK);
    assign timed_out = in_load && !rx_valid && (to_cnt == TO_LAST);
    assign len_new   = {len_hi_byte, rx_data};
    assign len_bad   = (len_new == 16'd0) || ({1'b0, len_new} > MAX_LEN);

    // Loader FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SYNC;
            rom_we      <= 1'b0;
            rom_addr    <= '0;
            rom_wdata   <= '0;
            cpu_reset   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            checksum    <= 8'd0;
            len_hi_byte <= 8'd0;
            hi_byte     <= 8'd0;
            len         <= 16'd0;
            word_cnt    <= 16'd0;
            to_cnt      <= '0;
        end else begin
            rom_we <= 1'b0;

            // Advance the address once the write pulse has been seen, but
            // never past the last word of the frame.
            if (rom_we && (word_cnt != len)) begin
                rom_addr <= rom_addr + ADDR_W'(1);
            end

            // Inter-byte watchdog, only meaningful while a frame is open.
            if (in_load && !rx_valid) begin
                to_cnt <= to_cnt + TO_W'(1);
            end else begin
                to_cnt <= '0;
            end

            if (in_load && (rx_ferr || timed_out)) begin
                state <= FAIL;
            end else begin
                case (state)
                    SYNC, RUN: begin
                        if (rx_valid && (rx_data == SYNC_BYTE)) begin
                            state     <= LEN_HI;
                            cpu_reset <= 1'b1;
                            done      <= 1'b0;
                            busy      <= 1'b1;
                            error     <= 1'b0;
                            checksum  <= 8'd0;
                            rom_addr  <= '0;
                            word_cnt  <= 16'd0;
                        end
                    end
                    LEN_HI: begin
                        if (rx_valid) begin
                            len_hi_byte <= rx_data;
                            checksum    <= checksum ^ rx_data;
                            state       <= LEN_LO;
                        end
                    end
                    LEN_LO: begin
                        if (rx_valid) begin
                            len      <= len_new;
                            checksum <= checksum ^ rx_data;
                            state    <= len_bad ? FAIL : DATA_HI;
                        end
                    end
                    DATA_HI: begin
                        if (rx_valid) begin
                            hi_byte  <= rx_data;
                            checksum <= checksum ^ rx_data;
                            state    <= DATA_LO;
                        end
                    end
                    DATA_LO: begin
                        if (rx_valid) begin
                            rom_we    <= 1'b1;
                            rom_wdata <= WIDTH'({hi_byte, rx_data});
                            checksum  <= checksum ^ rx_data;
                            word_cnt  <= word_cnt + 16'd1;
                            state     <= ((word_cnt + 16'd1) == len) ? CHECK : DATA_HI;
                        end
                    end
                    CHECK: begin
                        if (rx_valid) begin
                            if (rx_data == checksum) begin
                                state     <= RUN;
                                cpu_reset <= 1'b0;
                                done      <= 1'b1;
                                busy      <= 1'b0;
                            end else begin
                                state <= FAIL;
                            end
                        end
                    end
                    FAIL: begin
                        // ROM contents written so far are left as they are.
                        error     <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                        cpu_reset <= 1'b1;
                        state     <= SYNC;
                    end
                    default: state <= SYNC;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hack_rom_loader.sv
// ============================================================================
//  Module      : tb_hack_rom_loader
//  Description : Scoreboard bench for hack_rom_loader. Directed UART frames;
//                expected ROM writes are queued and checked by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hack_rom_loader;

    localparam int WIDTH       = 16;
    localparam int ADDR_W      = 15;
    localparam int CLK_FREQ    = 1000000;
    localparam int BAUD        = 100000;
    localparam int TIMEOUT_CYC = 5000;
    localparam int BIT_CYC     = 10;

    logic              clk     = 1'b0;
    logic              reset   = 1'b1;
    logic              uart_rx = 1'b1;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [WIDTH-1:0]  rom_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
    } wr_t;

    wr_t exp_q[$];

    always #5 clk = ~clk;

    hack_rom_loader #(
        .WIDTH       (WIDTH),
        .ADDR_W      (ADDR_W),
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_status(input string name, input logic cr, input logic dn,
                                input logic er, input logic bs);
        check({name, ".cpu_reset"}, 32'(cpu_reset), 32'(cr));
        check({name, ".done"},      32'(done),      32'(dn));
        check({name, ".error"},     32'(error),     32'(er));
        check({name, ".busy"},      32'(busy),      32'(bs));
    endtask

    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send_raw(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (BIT_CYC) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * BIT_CYC) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_raw(b, 1'b1);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (rom_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: addr=0x%0h data=0x%0h, expected no write",
                         rom_addr, rom_wdata);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(rom_addr), 32'(e.addr));
                check("write_data", 32'(rom_wdata), 32'(e.data));
            end
        end
    end

    // Run-time bound.
    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("reset.rom_we",    32'(rom_we),    32'h0);
        check("reset.rom_addr",  32'(rom_addr),  32'h0);
        check("reset.rom_wdata", 32'(rom_wdata), 32'h0);
        check_status("reset", 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (10000) @(negedge clk);
        check_status("idle", 1'b1, 1'b0, 1'b0, 1'b0);

        // Good two-word frame
        expect_write(15'd0, 16'h0005);
        expect_write(15'd1, 16'hEC10);
        send_byte(8'hA5);
        check_status("load1_sync", 1'b1, 1'b0, 1'b0, 1'b1);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h00); send_byte(8'h05);
        send_byte(8'hEC); send_byte(8'h10);
        send_byte(8'hFB);
        check_status("load1_done", 1'b0, 1'b1, 1'b0, 1'b0);

        // Same frame with a bad checksum (reload from RUN)
        expect_write(15'd0, 16'h0005);
        expect_write(15'd1, 16'hEC10);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h00); send_byte(8'h05);
        send_byte(8'hEC); send_byte(8'h10);
        send_byte(8'hFA);
        check_status("badchk", 1'b1, 1'b0, 1'b1, 1'b0);

        // Correct frame after a failure clears error
        expect_write(15'd0, 16'h0005);
        expect_write(15'd1, 16'hEC10);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h00); send_byte(8'h05);
        send_byte(8'hEC); send_byte(8'h10);
        send_byte(8'hFB);
        check_status("recover", 1'b0, 1'b1, 1'b0, 1'b0);

        // Non-sync byte in RUN is ignored, then a one-word reload
        send_byte(8'h3C);
        check_status("run_ignore", 1'b0, 1'b1, 1'b0, 1'b0);
        expect_write(15'd0, 16'h1234);
        send_byte(8'hA5);
        check_status("reload_sync", 1'b1, 1'b0, 1'b0, 1'b1);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h27);
        check_status("reload_done", 1'b0, 1'b1, 1'b0, 1'b0);

        // Timeout partway through a three-word frame
        expect_write(15'd0, 16'h0005);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h00); send_byte(8'h05);
        check_status("to_mid", 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (TIMEOUT_CYC + 10) @(negedge clk);
        check_status("timeout", 1'b1, 1'b0, 1'b1, 1'b0);
        send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
        check_status("after_to", 1'b1, 1'b0, 1'b1, 1'b0);

        // Framing error during DATA_HI
        send_byte(8'hA5);
        check_status("ferr_sync", 1'b1, 1'b0, 1'b0, 1'b1);
        send_byte(8'h00); send_byte(8'h02);
        send_raw(8'h12, 1'b0);
        check_status("ferr", 1'b1, 1'b0, 1'b1, 1'b0);

        // LEN = 0
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
        check_status("len0", 1'b1, 1'b0, 1'b1, 1'b0);

        // LEN = 2^ADDR_W is accepted (times out waiting for data)
        send_byte(8'hA5); send_byte(8'h80); send_byte(8'h00);
        check_status("len_max", 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (TIMEOUT_CYC + 10) @(negedge clk);
        check_status("len_max_to", 1'b1, 1'b0, 1'b1, 1'b0);

        // LEN = 2^ADDR_W + 1 is rejected
        send_byte(8'hA5);
        check_status("len_over_sync", 1'b1, 1'b0, 1'b0, 1'b1);
        send_byte(8'h80); send_byte(8'h01);
        check_status("len_over", 1'b1, 1'b0, 1'b1, 1'b0);

        repeat (20) @(negedge clk);
        check("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
